// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    localparam int unsigned DMEM_WAIT_W     = 4;
    localparam int unsigned DMEM_WORD_BYTES = 4;

endpackage

// File: rtl/dmem_ram_bank.sv
// Byte-lane write-enable synchronous RAM: 32-bit words, one-cycle registered read, no reset.
module dmem_ram_bank #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     wstrb,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Lane-masked write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core's load/store interface: one request at a time, word access under a lane mask.
// Optional macro DMEM_RANGE_CHECK_EN flags out-of-window addresses via resp_err and suppresses the access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned             IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_WAIT_W-1:0]  WAIT_INIT = DMEM_WAIT_W'(WAIT_STATES);

    dmem_state_t            state_q, state_d;
    logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   err_q, err_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;

    logic [31:0]            req_off_s;
    logic [IDX_W-1:0]       req_idx_s;
    logic                   req_oor_s;
    logic [IDX_W-1:0]       ram_idx_s;
    logic                   ram_we_s;
    logic [31:0]            ram_rdata_s;

    assign req_off_s = req_addr - BASE_ADDR;
    assign req_idx_s = req_off_s[2 +: IDX_W];

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * DMEM_WORD_BYTES);
    assign req_oor_s = (req_off_s >= SPAN_BYTES);
`else
    logic unused_off_s;
    assign req_oor_s    = 1'b0;
    assign unused_off_s = ^{req_off_s[1:0], req_off_s[31:IDX_W+2]};
`endif

    // Next-state, request latch and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        err_d        = err_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_idx_s    = idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    idx_d     = req_idx_s;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    err_d     = req_oor_s;
                    // Read the incoming word now so it is ready by the ACCESS cycle.
                    ram_idx_s = req_idx_s;
                    if (WAIT_STATES != 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                end else begin
                    state_d = WAIT;
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_rdata_d = (we_q || err_q) ? 32'h0000_0000 : ram_rdata_s;
                resp_err_d   = err_q;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    assign ram_we_s = (state_q == ACCESS) && we_q && !err_q && !rst;

    // State, latch and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'b0000;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    dmem_ram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .idx  (ram_idx_s),
        .wdata(wdata_q),
        .wstrb(wstrb_q),
        .rdata(ram_rdata_s)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic             clk;
    logic             rst;
    logic [1:0]       rv, we_s, rr;
    logic [1:0][31:0] addr_s, wd_s;
    logic [1:0][3:0]  ws_s;
    wire  [1:0]       rq, vq, eq;
    wire  [1:0][31:0] rd_s;

    int n_checks;
    int n_errors;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rq[0]), .req_we(we_s[0]), .req_addr(addr_s[0]),
        .req_wdata(wd_s[0]), .req_wstrb(ws_s[0]),
        .resp_valid(vq[0]), .resp_ready(rr[0]), .resp_rdata(rd_s[0]), .resp_err(eq[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rq[1]), .req_we(we_s[1]), .req_addr(addr_s[1]),
        .req_wdata(wd_s[1]), .req_wstrb(ws_s[1]),
        .resp_valid(vq[1]), .resp_ready(rr[1]), .resp_rdata(rd_s[1]), .resp_err(eq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d. Latency counts the accept edge as edge 1.
    // hold: cycles resp_ready stays low in RESP (a competing store is offered meanwhile).
    // glitch: offer a stray store to another address while the request is stalled.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wdat,
                        input logic [3:0] strb, input int hold, input bit glitch,
                        output logic [31:0] rdat, output logic err, output int lat,
                        output bit rdy_seen);
        int  k;
        bit  done;
        k = 0;
        while (rq[d] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (rq[d] !== 1'b1) check_eq("ready_timeout", {31'd0, rq[d]}, 32'd1);
        rv[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wd_s[d] = wdat; ws_s[d] = strb; rr[d] = 1'b0;
        @(posedge clk);
        lat = 0; rdy_seen = 1'b0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) rv[d] = 1'b0;
            if (glitch && lat == 2) begin
                rv[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = a + 32'd128; wd_s[d] = 32'd0; ws_s[d] = 4'hF;
            end
            if (glitch && lat == 3) rv[d] = 1'b0;
            if (vq[d] === 1'b1) done = 1'b1;
            else if (rq[d] !== 1'b0) rdy_seen = 1'b1;
        end
        if (!done) check_eq("resp_timeout", 32'd0, 32'd1);
        rdat = rd_s[d];
        err  = eq[d];
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                rv[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = a; wd_s[d] = 32'd0; ws_s[d] = 4'hF;
            end
            @(negedge clk);
            check_eq("hold_valid", {31'd0, vq[d]}, 32'd1);
            check_eq("hold_rdata", rd_s[d], rdat);
            check_eq("hold_no_ready", {31'd0, rq[d]}, 32'd0);
        end
        rv[d] = 1'b0;
        rr[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr[d] = 1'b0;
        check_eq("idle_after_hs", {30'd0, vq[d], rq[d]}, 32'd1);
    endtask

    logic [31:0] rdat;
    logic        err;
    int          lat;
    bit          rdy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        rv = 2'b00; we_s = 2'b00; rr = 2'b00;
        addr_s = '0; wd_s = '0; ws_s = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", {31'd0, rq[d]}, 32'd1);
            check_eq("rst_valid", {31'd0, vq[d]}, 32'd0);
            check_eq("rst_rdata", rd_s[d], 32'd0);
            check_eq("rst_err", {31'd0, eq[d]}, 32'd0);
        end

        // Full-word store then load.
        xact(0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("sw_rdata", rdat, 32'd0);
        check_eq("sw_err", {31'd0, err}, 32'd0);
        check_eq("sw_lat", 32'(lat), 32'd2);
        xact(0, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("lw_rdata", rdat, 32'hDEAD_BEEF);
        check_eq("lw_err", {31'd0, err}, 32'd0);
        check_eq("lw_lat", 32'(lat), 32'd2);

        // Single-lane store, then a store with no lanes enabled.
        xact(0, 1'b1, BASE + 32'd8, 32'h0000_AA00, 4'b0010, 0, 1'b0, rdat, err, lat, rdy);
        xact(0, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("lane1_rdata", rdat, 32'hDEAD_AAEF);
        xact(0, 1'b1, BASE + 32'd8, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("strb0_rdata", rdat, 32'd0);
        check_eq("strb0_lat", 32'(lat), 32'd2);
        xact(0, 1'b0, BASE + 32'd8, 32'd0, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("strb0_unchanged", rdat, 32'hDEAD_AAEF);

        // Response back-pressure with a competing store offered in RESP.
        xact(0, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 4, 1'b0, rdat, err, lat, rdy);
        check_eq("hold_load", rdat, 32'hDEAD_AAEF);
        xact(0, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("hold_no_store", rdat, 32'hDEAD_AAEF);

        // Wait-state instance: latency, ready low while stalled, stray request ignored.
        xact(1, 1'b1, BASE + 32'h40, 32'hCAFE_F00D, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("ws3_sw_lat", 32'(lat), 32'd5);
        xact(1, 1'b0, BASE + 32'h40, 32'd0, 4'h0, 0, 1'b1, rdat, err, lat, rdy);
        check_eq("ws3_lw_rdata", rdat, 32'hCAFE_F00D);
        check_eq("ws3_lw_lat", 32'(lat), 32'd5);
        check_eq("ws3_ready_low", {31'd0, rdy}, 32'd0);
        xact(1, 1'b1, BASE + 32'h40, 32'h1234_5678, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        xact(1, 1'b0, BASE + 32'h40, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("ws3_raw", rdat, 32'h1234_5678);

        // Window boundaries.
        xact(0, 1'b1, BASE, 32'h0BAD_0BAD, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
`ifdef DMEM_RANGE_CHECK_EN
        xact(0, 1'b1, BASE - 32'd4, 32'h5555_0001, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("oor_sw_err", {31'd0, err}, 32'd1);
        check_eq("oor_sw_lat", 32'(lat), 32'd2);
        xact(0, 1'b0, BASE - 32'd4, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("oor_lw_err", {31'd0, err}, 32'd1);
        check_eq("oor_lw_rdata", rdat, 32'd0);
        xact(0, 1'b0, BASE + 32'd4092, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("top_word_err", {31'd0, err}, 32'd0);
        xact(0, 1'b0, BASE, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("oor_ram_kept", rdat, 32'h0BAD_0BAD);
`else
        xact(0, 1'b1, BASE + 32'd4096, 32'h5555_0001, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("wrap_sw_err", {31'd0, err}, 32'd0);
        xact(0, 1'b0, BASE, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("wrap_word0", rdat, 32'h5555_0001);
        check_eq("wrap_lw_err", {31'd0, err}, 32'd0);
`endif

        // Reset during the ACCESS cycle of a store.
        xact(0, 1'b1, BASE, 32'h1111_1111, 4'hF, 0, 1'b0, rdat, err, lat, rdy);
        xact(0, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("pre_rst_rdata", rdat, 32'hDEAD_AAEF);
        rv[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = BASE; wd_s[0] = 32'h2222_2222; ws_s[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        rv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("arst_ready", {31'd0, rq[0]}, 32'd1);
        check_eq("arst_valid", {31'd0, vq[0]}, 32'd0);
        check_eq("arst_rdata", rd_s[0], 32'd0);
        check_eq("arst_err", {31'd0, eq[0]}, 32'd0);
        xact(0, 1'b0, BASE, 32'd0, 4'h0, 0, 1'b0, rdat, err, lat, rdy);
        check_eq("arst_word0", rdat, 32'h1111_1111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
